riscv_dmem_resp: RTL and testbench

Data-memory responder for the RV32I pipelined core: the target side of the core's single-cycle data-memory port (address, write enable, byte strobe, write data out; read data in). Provides a byte-strobed word RAM with combinational read, so the core's MM-stage load completes in the same cycle. Also provides a small MMIO page: a TX byte FIFO drained over a valid/ready stream, and an optional free-running timer with a compare interrupt.

---
 rtl/riscv_dmem_resp_pkg.sv | 44 ++++
 rtl/riscv_sync_fifo.sv | 54 +++++
 rtl/riscv_dmem_resp.sv | 219 +++++++++++++++++++++
 tb/tb_riscv_dmem_resp.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_dmem_resp_pkg.sv
// riscv_dmem_resp_pkg: shared constants for the data-memory responder.
// Contents: MMIO register offsets within the 4 KiB page, bit positions of
// the STATUS and IRQ registers, the default MMIO base, and a byte-lane
// merge helper used by the lane-strobed MMIO registers.
package riscv_dmem_resp_pkg;

    localparam int XLEN = 32;

    localparam logic [31:0] DEFAULT_MMIO_BASE = 32'h8000_0000;

    // Byte offsets of the word-wide MMIO registers inside the page
    localparam logic [11:0] OFF_TXDATA   = 12'h000;
    localparam logic [11:0] OFF_STATUS   = 12'h004;
    localparam logic [11:0] OFF_MTIME    = 12'h008;
    localparam logic [11:0] OFF_MTIMECMP = 12'h00C;
    localparam logic [11:0] OFF_IRQ      = 12'h010;

    // STATUS register layout
    localparam int STATUS_FULL_BIT  = 0;
    localparam int STATUS_EMPTY_BIT = 1;
    localparam int STATUS_OVF_BIT   = 2;
    localparam int STATUS_CNT_LSB   = 4;

    // IRQ register layout
    localparam int IRQ_EN_BIT   = 0;
    localparam int IRQ_PEND_BIT = 1;

    // Replace the bytes of old_word whose strobe bit is set
    function automatic logic [XLEN-1:0] lane_merge(
        input logic [XLEN-1:0] old_word,
        input logic [XLEN-1:0] new_word,
        input logic [3:0]      strb
    );
        logic [XLEN-1:0] merged;
        merged = old_word;
        for (int i = 0; i < 4; i++) begin
            if (strb[i]) begin
                merged[i*8 +: 8] = new_word[i*8 +: 8];
            end
        end
        return merged;
    endfunction

endpackage

// File: rtl/riscv_sync_fifo.sv
// riscv_sync_fifo: single-clock FIFO with read-ahead head output.
// Pointers carry one extra wrap bit so full and empty are distinguished
// without a separate counter. The caller must not push while full unless
// it pops in the same cycle. head_data reads 0 while the FIFO is empty.
module riscv_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                   i_clk,
    input  logic                   i_rstn,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop,
    output logic [WIDTH-1:0]       head_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr_reg;
    logic [AW:0]      rd_ptr_reg;

    // Storage write; contents need no reset because the pointers gate visibility
    always_ff @(posedge i_clk) begin
        if (push) begin
            mem[wr_ptr_reg[AW-1:0]] <= push_data;
        end
    end

    // Pointer advance; reset empties the FIFO
    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
        end
    end

    assign count     = wr_ptr_reg - rd_ptr_reg;
    assign empty     = (wr_ptr_reg == rd_ptr_reg);
    assign full      = (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]) &&
                       (wr_ptr_reg[AW] != rd_ptr_reg[AW]);
    assign head_data = empty ? '0 : mem[rd_ptr_reg[AW-1:0]];

endmodule

// File: rtl/riscv_dmem_resp.sv
// riscv_dmem_resp: target side of the RV32I core's data-memory port.
// Byte-strobed word RAM with combinational read, plus an MMIO page holding
// a TX byte FIFO (valid/ready drain) and an optional timer.
// Build option: define RISCV_DMEM_TIMER_EN to build MTIME, MTIMECMP and the
// IRQ register; without it those offsets read 0 and o_timer_irq is 0.
module riscv_dmem_resp
    import riscv_dmem_resp_pkg::*;
#(
    parameter int          RAM_WORDS  = 1024,
    parameter int          FIFO_DEPTH = 8,
    parameter logic [31:0] MMIO_BASE  = DEFAULT_MMIO_BASE
) (
    input  logic            i_clk,
    input  logic            i_rstn,
    input  logic [XLEN-1:0] i_dmem_addr,
    input  logic            i_dmem_wr_en,
    input  logic [3:0]      i_dmem_strb,
    input  logic [XLEN-1:0] i_dmem_wr_data,
    output logic [XLEN-1:0] o_dmem_rd_data,
    output logic            o_tx_valid,
    output logic [7:0]      o_tx_data,
    input  logic            i_tx_ready,
    output logic            o_timer_irq
);

    localparam int RAM_AW = $clog2(RAM_WORDS);
    localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;

    // ---------------- address decode ----------------
    logic              mmio_sel;
    logic [11:0]       mmio_off;
    logic [RAM_AW-1:0] ram_idx;
    logic              ram_we;
    logic              mmio_we;

    assign mmio_sel = (i_dmem_addr[31:12] == MMIO_BASE[31:12]);
    assign mmio_off = {i_dmem_addr[11:2], 2'b00};
    assign ram_idx  = i_dmem_addr[RAM_AW+1:2];
    assign ram_we   = i_dmem_wr_en && !mmio_sel;
    assign mmio_we  = i_dmem_wr_en && mmio_sel;

    // Byte-address bits never select anything; the core pre-aligns lanes
    logic unused_addr_bits;
    assign unused_addr_bits = ^i_dmem_addr[1:0];

    // ---------------- RAM: one byte-wide array per lane ----------------
    logic [XLEN-1:0] ram_rd;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] lane_mem [RAM_WORDS];

            // Lane write when its strobe is set; contents are never reset
            always_ff @(posedge i_clk) begin
                if (ram_we && i_dmem_strb[gi]) begin
                    lane_mem[ram_idx] <= i_dmem_wr_data[gi*8 +: 8];
                end
            end

            assign ram_rd[gi*8 +: 8] = lane_mem[ram_idx];
        end
    endgenerate

    // ---------------- TX FIFO ----------------
    logic             tx_write;
    logic             status_clr;
    logic             fifo_push;
    logic             fifo_pop;
    logic             fifo_full;
    logic             fifo_empty;
    logic [CNT_W-1:0] fifo_count;
    logic             overflow_reg;

    assign tx_write   = mmio_we && (mmio_off == OFF_TXDATA) && i_dmem_strb[0];
    assign status_clr = mmio_we && (mmio_off == OFF_STATUS) && i_dmem_strb[0] &&
                        i_dmem_wr_data[STATUS_OVF_BIT];
    assign fifo_pop   = !fifo_empty && i_tx_ready;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts
    assign fifo_push  = tx_write && (!fifo_full || fifo_pop);

    riscv_sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_tx_fifo (
        .i_clk     (i_clk),
        .i_rstn    (i_rstn),
        .push      (fifo_push),
        .push_data (i_dmem_wr_data[7:0]),
        .pop       (fifo_pop),
        .head_data (o_tx_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign o_tx_valid = !fifo_empty;

    // Sticky overflow: a dropped push sets it, writing 1 to STATUS bit 2 clears it
    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            overflow_reg <= 1'b0;
        end else if (tx_write && fifo_full && !fifo_pop) begin
            overflow_reg <= 1'b1;
        end else if (status_clr) begin
            overflow_reg <= 1'b0;
        end
    end

    // ---------------- timer ----------------
    logic [XLEN-1:0] mtime_val;
    logic [XLEN-1:0] mtimecmp_val;
    logic            irq_en;
    logic            irq_pend;

`ifdef RISCV_DMEM_TIMER_EN
    logic [XLEN-1:0] mtime_reg;
    logic [XLEN-1:0] mtimecmp_reg;
    logic            irq_en_reg;
    logic            irq_pend_reg;
    logic            irq_reg;
    logic            mtime_we;
    logic            cmp_we;
    logic            irq_we;

    assign mtime_we = mmio_we && (mmio_off == OFF_MTIME) && (i_dmem_strb != 4'h0);
    assign cmp_we   = mmio_we && (mmio_off == OFF_MTIMECMP);
    assign irq_we   = mmio_we && (mmio_off == OFF_IRQ) && i_dmem_strb[0];

    // Free-running counter; a CPU write replaces the increment that cycle
    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            mtime_reg <= '0;
        end else if (mtime_we) begin
            mtime_reg <= lane_merge(mtime_reg, i_dmem_wr_data, i_dmem_strb);
        end else begin
            mtime_reg <= mtime_reg + 32'd1;
        end
    end

    // Compare value, lane-merged on write
    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            mtimecmp_reg <= '1;
        end else if (cmp_we) begin
            mtimecmp_reg <= lane_merge(mtimecmp_reg, i_dmem_wr_data, i_dmem_strb);
        end
    end

    // Enable and pending; a match beats a same-cycle clear
    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            irq_en_reg   <= 1'b0;
            irq_pend_reg <= 1'b0;
        end else begin
            if (irq_we) begin
                irq_en_reg <= i_dmem_wr_data[IRQ_EN_BIT];
            end
            if (mtime_reg == mtimecmp_reg) begin
                irq_pend_reg <= 1'b1;
            end else if (irq_we && i_dmem_wr_data[IRQ_PEND_BIT]) begin
                irq_pend_reg <= 1'b0;
            end
        end
    end

    // Registered interrupt output, one cycle behind pending
    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            irq_reg <= 1'b0;
        end else begin
            irq_reg <= irq_pend_reg && irq_en_reg;
        end
    end

    assign mtime_val    = mtime_reg;
    assign mtimecmp_val = mtimecmp_reg;
    assign irq_en       = irq_en_reg;
    assign irq_pend     = irq_pend_reg;
    assign o_timer_irq  = irq_reg;
`else
    assign mtime_val    = '0;
    assign mtimecmp_val = '0;
    assign irq_en       = 1'b0;
    assign irq_pend     = 1'b0;
    assign o_timer_irq  = 1'b0;
`endif

    // ---------------- read path ----------------
    logic [XLEN-1:0] status_word;
    logic [XLEN-1:0] irq_word;
    logic [XLEN-1:0] mmio_rd;

    // Assemble the STATUS and IRQ register images
    always_comb begin
        status_word                          = '0;
        status_word[STATUS_FULL_BIT]         = fifo_full;
        status_word[STATUS_EMPTY_BIT]        = fifo_empty;
        status_word[STATUS_OVF_BIT]          = overflow_reg;
        status_word[STATUS_CNT_LSB +: 4]     = 4'(fifo_count);
        irq_word                             = '0;
        irq_word[IRQ_EN_BIT]                 = irq_en;
        irq_word[IRQ_PEND_BIT]               = irq_pend;
    end

    // MMIO register select; TXDATA and unmapped offsets read 0
    always_comb begin
        mmio_rd = '0;
        case (mmio_off)
            OFF_STATUS:   mmio_rd = status_word;
            OFF_MTIME:    mmio_rd = mtime_val;
            OFF_MTIMECMP: mmio_rd = mtimecmp_val;
            OFF_IRQ:      mmio_rd = irq_word;
            default:      mmio_rd = '0;
        endcase
    end

    assign o_dmem_rd_data = mmio_sel ? mmio_rd : ram_rd;

endmodule

// File: tb/tb_riscv_dmem_resp.sv
// tb_riscv_dmem_resp: directed literal checks plus a randomized phase, all
// compared every cycle against a queue/array model of the responder.
module tb_riscv_dmem_resp;

    localparam int          RAM_WORDS  = 1024;
    localparam int          FIFO_DEPTH = 8;
    localparam logic [31:0] MMIO_BASE  = 32'h8000_0000;
`ifdef RISCV_DMEM_TIMER_EN
    localparam bit TIMER = 1'b1;
`else
    localparam bit TIMER = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rstn;
    logic [31:0] dmem_addr;
    logic        dmem_wr_en;
    logic [3:0]  dmem_strb;
    logic [31:0] dmem_wr_data;
    logic [31:0] dmem_rd_data;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        tx_ready;
    logic        timer_irq;

    int total = 0;
    int bad   = 0;
    bit log_en = 1'b1;

    riscv_dmem_resp #(
        .RAM_WORDS  (RAM_WORDS),
        .FIFO_DEPTH (FIFO_DEPTH),
        .MMIO_BASE  (MMIO_BASE)
    ) dut (
        .i_clk          (clk),
        .i_rstn         (rstn),
        .i_dmem_addr    (dmem_addr),
        .i_dmem_wr_en   (dmem_wr_en),
        .i_dmem_strb    (dmem_strb),
        .i_dmem_wr_data (dmem_wr_data),
        .o_dmem_rd_data (dmem_rd_data),
        .o_tx_valid     (tx_valid),
        .o_tx_data      (tx_data),
        .i_tx_ready     (tx_ready),
        .o_timer_irq    (timer_irq)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    logic [31:0] mram [int];
    logic [7:0]  mq [$];
    logic        m_ovf;
    logic [31:0] m_mtime;
    logic [31:0] m_cmp;
    logic        m_en;
    logic        m_pend;
    logic        m_irq;
    bit          started = 1'b0;

    function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n,
                                          input logic [3:0] s);
        logic [31:0] r;
        r = o;
        for (int b = 0; b < 4; b++) if (s[b]) r[b*8 +: 8] = n[b*8 +: 8];
        return r;
    endfunction

    function automatic logic [31:0] model_read(input logic [31:0] a);
        logic [31:0] r;
        logic [11:0] off;
        int          idx;
        r = 32'h0;
        if (a[31:12] != MMIO_BASE[31:12]) begin
            idx = int'((a >> 2) % RAM_WORDS);
            r = mram.exists(idx) ? mram[idx] : 32'hxxxx_xxxx;
        end else begin
            off = {a[11:2], 2'b00};
            if (off == 12'h004) begin
                r[0]   = (mq.size() == FIFO_DEPTH);
                r[1]   = (mq.size() == 0);
                r[2]   = m_ovf;
                r[7:4] = 4'(mq.size());
            end else if (off == 12'h008) r = TIMER ? m_mtime : 32'h0;
            else if (off == 12'h00C)     r = TIMER ? m_cmp : 32'h0;
            else if (off == 12'h010)     r = TIMER ? {30'h0, m_pend, m_en} : 32'h0;
        end
        return r;
    endfunction

    task automatic model_step();
        logic        mm;
        logic [11:0] off;
        int          idx;
        logic        match;
        logic        clr;
        logic        nxt_irq;
        logic [31:0] nxt_mtime;
        if (!rstn) begin
            mq.delete();
            m_ovf = 1'b0; m_mtime = 32'h0; m_cmp = 32'hFFFF_FFFF;
            m_en = 1'b0; m_pend = 1'b0; m_irq = 1'b0;
            started = 1'b1;
            return;
        end
        if (!started) return;
        mm        = (dmem_addr[31:12] == MMIO_BASE[31:12]);
        off       = {dmem_addr[11:2], 2'b00};
        idx       = int'((dmem_addr >> 2) % RAM_WORDS);
        match     = (m_mtime == m_cmp);
        nxt_irq   = m_pend & m_en;
        nxt_mtime = m_mtime + 32'd1;
        clr       = 1'b0;
        // The sink takes the head first, so a full FIFO has room for this cycle's push
        if (mq.size() != 0 && tx_ready) void'(mq.pop_front());
        if (dmem_wr_en) begin
            if (!mm) begin
                if (!mram.exists(idx)) mram[idx] = 32'hxxxx_xxxx;
                mram[idx] = merge(mram[idx], dmem_wr_data, dmem_strb);
            end else if (off == 12'h000 && dmem_strb[0]) begin
                if (mq.size() < FIFO_DEPTH) mq.push_back(dmem_wr_data[7:0]);
                else m_ovf = 1'b1;
            end else if (off == 12'h004 && dmem_strb[0] && dmem_wr_data[2]) begin
                m_ovf = 1'b0;
            end else if (off == 12'h008 && dmem_strb != 4'h0) begin
                nxt_mtime = merge(m_mtime, dmem_wr_data, dmem_strb);
            end else if (off == 12'h00C) begin
                m_cmp = merge(m_cmp, dmem_wr_data, dmem_strb);
            end else if (off == 12'h010 && dmem_strb[0]) begin
                m_en = dmem_wr_data[0];
                clr  = dmem_wr_data[1];
            end
        end
        m_mtime = nxt_mtime;
        m_pend  = match | (m_pend & ~clr);
        m_irq   = TIMER ? nxt_irq : 1'b0;
    endtask

    initial begin
        forever begin
            @(posedge clk);
            model_step();
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%08h exp=%08h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Per-cycle compare against the model
    initial begin
        logic [31:0] exp_rd;
        forever begin
            @(negedge clk);
            if (started) begin
                exp_rd = model_read(dmem_addr);
                if (!$isunknown(exp_rd)) chk("rd_data", dmem_rd_data, exp_rd);
                chk("tx_valid", 32'(tx_valid), 32'(mq.size() != 0));
                chk("tx_data", 32'(tx_data), (mq.size() != 0) ? 32'(mq[0]) : 32'h0);
                chk("timer_irq", 32'(timer_irq), 32'(m_irq));
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic drive(input logic w, input logic [31:0] a, input logic [3:0] s,
                         input logic [31:0] d, input logic r);
        @(posedge clk);
        #1;
        rstn = 1'b1; dmem_wr_en = w; dmem_addr = a; dmem_strb = s;
        dmem_wr_data = d; tx_ready = r;
        @(negedge clk);
        if (log_en)
            $display("txn w=%0d addr=%08h strb=%h wdata=%08h rdy=%0d rdata=%08h valid=%0d txd=%02h irq=%0d",
                     w, a, s, d, r, dmem_rd_data, tx_valid, tx_data, timer_irq);
    endtask

    task automatic reset_cycle();
        @(posedge clk);
        #1;
        rstn = 1'b0; dmem_wr_en = 1'b0; tx_ready = 1'b0;
        @(negedge clk);
    endtask

    task automatic rand_cycle();
        int unsigned kind;
        logic [31:0] a;
        logic [31:0] d;
        logic [3:0]  s;
        logic        w;
        logic        r;
        kind = $urandom_range(0, 9);
        r    = 1'($urandom_range(0, 1));
        d    = $urandom;
        s    = 4'($urandom);
        w    = 1'b0;
        a    = ($urandom & 32'h7FFF_F000) | ($urandom_range(0, 63) << 2) | $urandom_range(0, 3);
        case (kind)
            0, 1: w = 1'b1;
            2:    w = 1'b0;
            3, 4: begin w = 1'b1; a = MMIO_BASE; s[0] = 1'b1; end
            5:    begin w = 1'b1; a = MMIO_BASE + 32'h4; end
            6:    begin w = 1'b1; a = MMIO_BASE + 32'hC; s = 4'hF;
                        d = m_mtime + $urandom_range(2, 40); end
            7:    begin w = 1'b1; a = MMIO_BASE + (32'($urandom_range(2, 4)) << 2); end
            default: a = ($urandom_range(0, 7) == 0) ? MMIO_BASE + 32'hFFC
                                                       : MMIO_BASE + (32'($urandom_range(0, 7)) << 2);
        endcase
        drive(w, a, s, d, r);
    endtask

    logic [7:0] stream1 [3] = '{8'h41, 8'h42, 8'h43};
    logic [7:0] stream2 [8] = '{8'h51, 8'h52, 8'h53, 8'h54, 8'h55, 8'h56, 8'h57, 8'h60};

    initial begin
        bit found;
        rstn = 1'b0; dmem_wr_en = 1'b0; dmem_addr = 32'h0; dmem_strb = 4'h0;
        dmem_wr_data = 32'h0; tx_ready = 1'b0;
        repeat (2) @(negedge clk);

        // Reset state
        drive(1'b0, MMIO_BASE + 32'h4, 4'h0, 32'h0, 1'b0);
        chk("rst_status", dmem_rd_data, 32'h02);
        chk("rst_valid", 32'(tx_valid), 32'h0);
        chk("rst_txdata", 32'(tx_data), 32'h0);
        chk("rst_irq", 32'(timer_irq), 32'h0);
        drive(1'b0, MMIO_BASE + 32'hC, 4'h0, 32'h0, 1'b0);
        chk("rst_mtimecmp", dmem_rd_data, TIMER ? 32'hFFFF_FFFF : 32'h0);
        drive(1'b0, MMIO_BASE + 32'h10, 4'h0, 32'h0, 1'b0);
        chk("rst_irqreg", dmem_rd_data, 32'h0);

        // RAM lane merge
        drive(1'b1, 32'h0000_0010, 4'hF, 32'hDEAD_BEEF, 1'b0);
        drive(1'b1, 32'h0000_0010, 4'h2, 32'h0000_AA00, 1'b0);
        drive(1'b0, 32'h0000_0010, 4'h0, 32'h0, 1'b0);
        chk("ram_merge", dmem_rd_data, 32'hDEAD_AAEF);

        // Three pushes with sink stalled, then drain
        drive(1'b1, MMIO_BASE, 4'h1, 32'h41, 1'b0);
        drive(1'b1, MMIO_BASE, 4'h1, 32'h42, 1'b0);
        drive(1'b1, MMIO_BASE, 4'h1, 32'h43, 1'b0);
        drive(1'b0, MMIO_BASE + 32'h4, 4'h0, 32'h0, 1'b0);
        chk("fifo3_status", dmem_rd_data, 32'h30);
        for (int k = 0; k < 3; k++) begin
            drive(1'b0, MMIO_BASE + 32'h4, 4'h0, 32'h0, 1'b1);
            chk("stream1_valid", 32'(tx_valid), 32'h1);
            chk("stream1_data", 32'(tx_data), 32'(stream1[k]));
        end
        drive(1'b0, MMIO_BASE + 32'h4, 4'h0, 32'h0, 1'b1);
        chk("drained_valid", 32'(tx_valid), 32'h0);
        chk("drained_status", dmem_rd_data, 32'h02);

        // Overflow: nine pushes into an eight-entry FIFO
        for (int k = 0; k < 9; k++) drive(1'b1, MMIO_BASE, 4'h1, 32'h50 + 32'(k), 1'b0);
        drive(1'b0, MMIO_BASE + 32'h4, 4'h0, 32'h0, 1'b0);
        chk("ovf_status", dmem_rd_data, 32'h85);
        drive(1'b1, MMIO_BASE + 32'h4, 4'h1, 32'h4, 1'b0);
        drive(1'b0, MMIO_BASE + 32'h4, 4'h0, 32'h0, 1'b0);
        chk("ovf_cleared", dmem_rd_data, 32'h81);
        // Push while full with the sink ready: both sides accepted
        drive(1'b1, MMIO_BASE, 4'h1, 32'h60, 1'b1);
        chk("full_pushpop_head", 32'(tx_data), 32'h50);
        drive(1'b0, MMIO_BASE + 32'h4, 4'h0, 32'h0, 1'b0);
        chk("full_pushpop_status", dmem_rd_data, 32'h81);
        for (int k = 0; k < 8; k++) begin
            drive(1'b0, MMIO_BASE + 32'h4, 4'h0, 32'h0, 1'b1);
            chk("stream2_data", 32'(tx_data), 32'(stream2[k]));
        end
        drive(1'b0, MMIO_BASE + 32'h4, 4'h0, 32'h0, 1'b0);
        chk("stream2_end", dmem_rd_data, 32'h02);

`ifdef RISCV_DMEM_TIMER_EN
        // Compare match to interrupt, then clear
        drive(1'b1, MMIO_BASE + 32'h10, 4'h1, 32'h2, 1'b0);
        drive(1'b1, MMIO_BASE + 32'hC, 4'hF, 32'd20, 1'b0);
        drive(1'b1, MMIO_BASE + 32'h10, 4'h1, 32'h1, 1'b0);
        drive(1'b1, MMIO_BASE + 32'h8, 4'hF, 32'h0, 1'b0);
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            drive(1'b0, MMIO_BASE + 32'h8, 4'h0, 32'h0, 1'b0);
            if (dmem_rd_data == 32'd20) found = 1'b1;
            else chk("tmr_irq_early", 32'(timer_irq), 32'h0);
        end
        chk("tmr_reach20", 32'(found), 32'h1);
        drive(1'b0, MMIO_BASE + 32'h8, 4'h0, 32'h0, 1'b0);
        chk("tmr_irq_plus1", 32'(timer_irq), 32'h0);
        drive(1'b0, MMIO_BASE + 32'h8, 4'h0, 32'h0, 1'b0);
        chk("tmr_irq_plus2", 32'(timer_irq), 32'h1);
        drive(1'b1, MMIO_BASE + 32'h10, 4'h1, 32'h3, 1'b0);
        chk("tmr_clr_cycle", 32'(timer_irq), 32'h1);
        drive(1'b0, MMIO_BASE + 32'h10, 4'h0, 32'h0, 1'b0);
        chk("tmr_clr_effect", dmem_rd_data, 32'h1);
        chk("tmr_clr_irq_hold", 32'(timer_irq), 32'h1);
        drive(1'b0, MMIO_BASE + 32'h10, 4'h0, 32'h0, 1'b0);
        chk("tmr_irq_dropped", 32'(timer_irq), 32'h0);
`else
        found = 1'b1;
        drive(1'b1, MMIO_BASE + 32'h8, 4'hF, 32'h1234_5678, 1'b0);
        drive(1'b0, MMIO_BASE + 32'h8, 4'h0, 32'h0, 1'b0);
        chk("notimer_mtime", dmem_rd_data, 32'h0);
`endif

        // Reset in the middle of a stream
        for (int k = 0; k < 5; k++) drive(1'b1, MMIO_BASE, 4'h1, 32'h70 + 32'(k), 1'b0);
        drive(1'b0, MMIO_BASE + 32'h4, 4'h0, 32'h0, 1'b0);
        chk("pre_rst_status", dmem_rd_data, 32'h50);
        reset_cycle();
        drive(1'b0, MMIO_BASE + 32'h8, 4'h0, 32'h0, 1'b0);
        chk("mid_rst_mtime", dmem_rd_data, 32'h0);
        chk("mid_rst_valid", 32'(tx_valid), 32'h0);
        drive(1'b0, MMIO_BASE + 32'h4, 4'h0, 32'h0, 1'b0);
        chk("mid_rst_status", dmem_rd_data, 32'h02);
        drive(1'b0, 32'h0000_0010, 4'h0, 32'h0, 1'b0);
        chk("mid_rst_ram", dmem_rd_data, 32'hDEAD_AAEF);

        // Randomized traffic checked by the per-cycle compare
        log_en = 1'b0;
        for (int n = 0; n < 3000; n++) rand_cycle();
        drive(1'b0, 32'h0, 4'h0, 32'h0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
